// File: rtl/req_capture_encoder.sv
// Sticky request capture with mask, lowest-index grant and valid/ready handshake.
// Build option REQ_EDGE_DETECT_EN: capture on rising edges of req instead of levels.

module req_capture_lane (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic clr,
    output logic pend,
    output logic drop
);
    logic ev;

`ifdef REQ_EDGE_DETECT_EN
    logic req_d;

    always_ff @(posedge clk) begin
        if (rst) req_d <= 1'b0;
        else     req_d <= req;
    end

    assign ev = req & ~req_d;
`else
    assign ev = req;
`endif

    // A fresh event beats the grant's clear on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) pend <= 1'b0;
        else     pend <= ev | (pend & ~clr);
    end

    assign drop = ev & pend & ~clr;
endmodule

module req_capture_encoder #(
    parameter logic [3:0] MASK_RESET = 4'b0000,
    parameter int         DROP_CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic                  mask_wr,
    input  logic [3:0]            mask_in,
    input  logic                  code_ready,
    output logic                  code_valid,
    output logic [1:0]            code,
    output logic [3:0]            pending,
    output logic [DROP_CNT_W-1:0] drop_cnt
);
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t     state, state_nx;
    logic [1:0] code_nx;
    logic [3:0] mask, eligible, clr, drop;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign clr[i] = code_valid & code_ready & (code == 2'(i));
        req_capture_lane u_lane (
            .clk  (clk),
            .rst  (rst),
            .req  (req[i]),
            .clr  (clr[i]),
            .pend (pending[i]),
            .drop (drop[i])
        );
    end

    assign eligible   = pending & ~mask;
    assign code_valid = (state == PRESENT);

    always_comb begin
        state_nx = state;
        code_nx  = code;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_nx = PRESENT;
                    for (int k = 3; k >= 0; k--)
                        if (eligible[k]) code_nx = 2'(k);
                end
            end
            PRESENT: begin
                // Grant stays frozen until taken, even if a lower index arrives.
                if (code_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            code     <= 2'b00;
            mask     <= MASK_RESET;
            drop_cnt <= '0;
        end else begin
            state <= state_nx;
            code  <= code_nx;
            if (mask_wr) mask <= mask_in;
            if (|drop && drop_cnt != {DROP_CNT_W{1'b1}})
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_req_capture_encoder.sv
// Bench for req_capture_encoder: directed literal checks plus randomized run
// compared every cycle against a behavioural model.

module tb_req_capture_encoder;
    localparam int DW = 2;
    localparam int DMAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic          mask_wr;
    logic [3:0]    mask_in;
    logic          code_ready;
    logic          code_valid;
    logic [1:0]    code;
    logic [3:0]    pending;
    logic [DW-1:0] drop_cnt;

    int checks = 0;
    int passes = 0;
    bit started = 1'b0;

    req_capture_encoder #(.MASK_RESET(4'b0000), .DROP_CNT_W(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .mask_wr(mask_wr), .mask_in(mask_in),
        .code_ready(code_ready), .code_valid(code_valid), .code(code),
        .pending(pending), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Model state: plain per-line flags, a grant slot, a drop tally.
    bit m_pend[4];
    bit m_mask[4];
    bit m_prev[4];
    bit m_valid;
    int m_code;
    int m_drops;

    function automatic logic [3:0] pack(input bit a[4]);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = a[i];
        return v;
    endfunction

    always @(posedge clk) begin
        bit ev[4];
        bit npend[4];
        bit any_drop;
        int served;
        int pick;
        started <= 1'b1;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_pend[i] <= 1'b0; m_mask[i] <= 1'b0; m_prev[i] <= 1'b0;
            end
            m_valid <= 1'b0; m_code <= 0; m_drops <= 0;
        end else begin
            served = (m_valid && code_ready) ? m_code : -1;
            any_drop = 1'b0;
            pick = -1;
            for (int i = 0; i < 4; i++) begin
`ifdef REQ_EDGE_DETECT_EN
                ev[i] = req[i] && !m_prev[i];
`else
                ev[i] = req[i];
`endif
                if (ev[i] && m_pend[i] && served != i) any_drop = 1'b1;
                npend[i] = ev[i] || (m_pend[i] && served != i);
                if (pick < 0 && m_pend[i] && !m_mask[i]) pick = i;
            end
            for (int i = 0; i < 4; i++) begin
                m_pend[i] <= npend[i];
                m_prev[i] <= req[i];
                if (mask_wr) m_mask[i] <= mask_in[i];
            end
            if (any_drop && m_drops < DMAX) m_drops <= m_drops + 1;
            if (m_valid) begin
                if (code_ready) m_valid <= 1'b0;
            end else if (pick >= 0) begin
                m_valid <= 1'b1;
                m_code  <= pick;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("m_valid", int'(code_valid), int'(m_valid));
            if (m_valid) check("m_code", int'(code), m_code);
            check("m_pending", int'(pending), int'(pack(m_pend)));
            check("m_drop_cnt", int'(drop_cnt), m_drops);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_state(input string tag, input int v, input int c, input int p);
        check({tag, "_valid"}, int'(code_valid), v);
        if (v != 0) check({tag, "_code"}, int'(code), c);
        check({tag, "_pending"}, int'(pending), p);
    endtask

    initial begin
        rst = 1'b1; req = 4'h0; mask_wr = 1'b0; mask_in = 4'h0; code_ready = 1'b0;
        step(); step();
        expect_state("reset", 0, 0, 0);
        check("reset_code", int'(code), 0);
        check("reset_drop", int'(drop_cnt), 0);

        // Single request on line 2.
        rst = 1'b0; req = 4'b0100; step();
        expect_state("t1_capture", 0, 0, 4'b0100);
        req = 4'b0000; step();
        expect_state("t1_grant", 1, 2, 4'b0100);
        code_ready = 1'b1; step();
        expect_state("t1_accept", 0, 0, 4'b0000);

        // Three lines, consumer always ready: 0,1,3 on alternate cycles.
        req = 4'b1011; step();
        expect_state("t2_capture", 0, 0, 4'b1011);
        req = 4'b0000; step();
        expect_state("t2_g0", 1, 0, 4'b1011);
        step(); expect_state("t2_a0", 0, 0, 4'b1010);
        step(); expect_state("t2_g1", 1, 1, 4'b1010);
        step(); expect_state("t2_a1", 0, 0, 4'b1000);
        step(); expect_state("t2_g3", 1, 3, 4'b1000);
        step(); expect_state("t2_a3", 0, 0, 4'b0000);
        check("t2_drop", int'(drop_cnt), 0);

        // Mask line 0: line 1 wins, then unmask and line 0 follows.
        code_ready = 1'b0; mask_in = 4'b0001; mask_wr = 1'b1; step();
        mask_wr = 1'b0; req = 4'b0011; step();
        req = 4'b0000; step();
        expect_state("t3_g1", 1, 1, 4'b0011);
        code_ready = 1'b1; mask_in = 4'b0000; mask_wr = 1'b1; step();
        expect_state("t3_a1", 0, 0, 4'b0001);
        mask_wr = 1'b0; step();
        expect_state("t3_g0", 1, 0, 4'b0001);
        step();
        expect_state("t3_a0", 0, 0, 4'b0000);

        // Drops on line 2 while its grant waits, then saturation.
        code_ready = 1'b0; req = 4'b0100; step();
        req = 4'b0000; step();
        for (int n = 0; n < 2; n++) begin
            req = 4'b0100; step(); req = 4'b0000; step();
        end
        check("t4_drop2", int'(drop_cnt), 2);
        for (int n = 0; n < 5; n++) begin
            req = 4'b0100; step(); req = 4'b0000; step();
        end
        check("t4_drop_sat", int'(drop_cnt), 3);

        // Lower index arriving mid-grant waits for the next selection.
        req = 4'b0001; step(); req = 4'b0000; step();
        expect_state("t5_hold", 1, 2, 4'b0101);
        code_ready = 1'b1; step();
        expect_state("t5_a2", 0, 0, 4'b0001);
        step();
        expect_state("t5_g0", 1, 0, 4'b0001);
        step();
        expect_state("t5_a0", 0, 0, 4'b0000);

        // Reset while presenting with ready high.
        code_ready = 1'b0; req = 4'b0010; step(); req = 4'b0000; step();
        expect_state("t6_g1", 1, 1, 4'b0010);
        code_ready = 1'b1; rst = 1'b1; step();
        expect_state("t6_reset", 0, 0, 4'b0000);
        check("t6_code", int'(code), 0);
        check("t6_drop", int'(drop_cnt), 0);
        rst = 1'b0; code_ready = 1'b0;

        // Randomized traffic; model comparison runs every cycle.
        for (int n = 0; n < 3000; n++) begin
            req        = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            code_ready = ($urandom_range(0, 2) != 0);
            mask_wr    = ($urandom_range(0, 15) == 0);
            mask_in    = 4'($urandom) & 4'($urandom);
            rst        = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/req_capture_encoder.md
Name: req_capture_encoder

Overview:
- Upstream request-capture stage for the 4-to-2 priority encoder path.
- Latches four asynchronous-in-time request lines into a sticky pending register and applies a per-line mask.
- Selects the lowest-index eligible request (bit 0 highest priority, same ordering as the encoder) and presents its 2-bit code with a valid/ready handshake.
- Clears the served request on acceptance.

Parameters:
- MASK_RESET, 4'b0000, reset value of the mask register (1 = line blocked from selection).
- DROP_CNT_W, 4, width of the saturating dropped-request counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines, one per source.
- mask_wr  input  1  load mask_in into the mask register at the next edge.
- mask_in  input  4  new mask value.
- code_ready  input  1  consumer accepts the presented code.
- code_valid  output  1  code holds a valid grant.
- code  output  2  index of the granted request.
- pending  output  4  current pending register.
- drop_cnt  output  DROP_CNT_W  count of cycles in which a request was lost.

Behaviour:
- Reset (rst=1 at an edge):
  - pending=0, code_valid=0, code=2'b00, mask=MASK_RESET, drop_cnt=0, req_d=0, FSM=IDLE.
  - Reset mid-PRESENT abandons the grant; no pending bit is cleared by the handshake in that cycle.
- Capture event per bit i:
  - ev[i] = req[i] (level mode), or req[i] & ~req_d[i] (edge mode, see Optional Feature).
  - req_d is the registered copy of req.
- Pending update per edge: pending_next[i] = ev[i] | (pending[i] & ~clr[i]).
  - clr[i] = code_valid & code_ready & (code == i).
  - Set wins over clear when both occur on the same bit in the same cycle; this is not counted as a drop.
- Drop detection:
  - A drop is ev[i] on a bit with pending[i]=1 and clr[i]=0.
  - drop_cnt increments by 1 in any cycle with at least one drop, however many bits dropped.
  - drop_cnt saturates at 2^DROP_CNT_W-1.
- Masking:
  - Masked bits still capture and pend.
  - eligible = pending & ~mask.
  - mask_wr takes effect at the next edge.
- FSM, two states:
  - IDLE: code_valid=0. If eligible != 0, at the next edge set code_valid=1, set code = lowest set index of eligible, go to PRESENT.
  - PRESENT: code and code_valid are held stable regardless of req, mask or pending changes. If code_valid & code_ready, clear pending[code] at that edge, code_valid=0 next cycle, go to IDLE. Otherwise stay.
- Latency:
  - req sampled at edge E sets pending after E.
  - code_valid rises after E+1.
  - Minimum one IDLE cycle between successive grants, so maximum throughput is 1 grant per 2 cycles.
- Boundaries:
  - All four lines pending: granted in order 0,1,2,3 as each is accepted. A newly arriving lower index preempts at the next selection, never the current grant.
  - All eligible bits masked: code_valid stays 0, pending retained.
  - code_ready high while code_valid=0 is ignored.

Optional Feature:
- Macro: REQ_EDGE_DETECT_EN.
- Defined: ev = rising edge of req (req & ~req_d). A line held high pends once. A line held high across reset release counts as one edge on the first post-reset cycle.
- Undefined: ev = req level. A line held high re-pends every cycle, including the cycle its grant is accepted, since set wins. While already pending it counts drops.

Test Plan:
- Reset, then req=4'b0100 for one cycle (edge mode), no mask -> pending=0100 after edge E, code_valid=1 and code=2'b10 after E+1. code_ready=1 for one cycle -> pending=0000, code_valid=0.
- req=4'b1011 pulse, code_ready held 1 -> grants code 00, 01, 11 on every second cycle; pending ends 0000; drop_cnt=0.
- mask_in=4'b0001 with mask_wr, then req=4'b0011 pulse -> code=01 granted first. Then mask cleared with mask_wr -> code=00 granted next.
- Pulse req[2] twice while pending[2]=1 and code_ready=0, with DROP_CNT_W=2 -> drop_cnt=2. Five more such pulses -> drop_cnt saturates at 3.
- While PRESENT with code=10, pulse req[0] -> code stays 10 until accepted, then the next grant is code=00.
- Assert rst during PRESENT with code_ready=1 -> code_valid=0, code=00, pending=0000, drop_cnt=0 after the edge.
